// File: rtl/div_8bit_pkg.sv
// Shared arithmetic package for the signed divider (and its sibling multiplier).
// Holds operand widths, the iteration count, the FSM state encoding and
// small two's-complement magnitude helpers.
package div_8bit_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int ITER_N     = 16;
    localparam int CNT_W      = $clog2(ITER_N);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Magnitude of a signed value, returned unsigned at the same width.
    // The most negative input maps to 2**(W-1), which still fits unsigned.
    function automatic logic [DIVIDEND_W-1:0] mag16(input logic [DIVIDEND_W-1:0] v);
        return v[DIVIDEND_W-1] ? ((~v) + DIVIDEND_W'(1)) : v;
    endfunction

    function automatic logic [DIVISOR_W-1:0] mag8(input logic [DIVISOR_W-1:0] v);
        return v[DIVISOR_W-1] ? ((~v) + DIVISOR_W'(1)) : v;
    endfunction

endpackage

// File: rtl/div_8bit_if.sv
// Request/result bundle for div_8bit.
//   start, dividend, divisor : request side (driven by master)
//   quot, rem, busy, done,
//   ovf, dbz                 : result/status side (driven by slave)
interface div_8bit_if;
    import div_8bit_pkg::*;

    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic [DIVISOR_W-1:0]  quot;
    logic [DIVISOR_W-1:0]  rem;
    logic                  busy;
    logic                  done;
    logic                  ovf;
    logic                  dbz;

    modport master (
        output start, dividend, divisor,
        input  quot, rem, busy, done, ovf, dbz
    );

    modport slave (
        input  start, dividend, divisor,
        output quot, rem, busy, done, ovf, dbz
    );

endinterface

// File: rtl/div_sub.sv
// Trial subtractor for the restoring divider.
//   a, b   : unsigned operands (W bits)
//   diff   : a - b (W bits)
//   borrow : 1 when a < b
module div_sub #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/div_8bit.sv
// Signed 16/8 restoring divider, one quotient bit per clock.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : div_8bit_if.slave -- start/dividend/divisor in,
//         quot/rem/busy/done/ovf/dbz out (all outputs registered)
// Division runs on magnitudes; signs are re-applied when the last bit is
// produced so results land in their registers on the same edge DONE is entered.
module div_8bit
    import div_8bit_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    div_8bit_if.slave bus
);

    state_t                state_reg;
    logic [CNT_W-1:0]      cnt_reg;
    // Holds the dividend magnitude; its MSB is shifted into the partial
    // remainder each step while the new quotient bit enters at the LSB.
    logic [DIVIDEND_W-1:0] q_reg;
    logic [DIVISOR_W-1:0]  r_reg;
    logic [DIVISOR_W-1:0]  dvs_mag_reg;
    logic                  neg_q_reg;
    logic                  neg_r_reg;

    logic [DIVISOR_W-1:0]  quot_reg;
    logic [DIVISOR_W-1:0]  rem_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  ovf_reg;
    logic                  dbz_reg;

    logic [DIVISOR_W:0]    trial_a;
    logic [DIVISOR_W:0]    trial_b;
    logic [DIVISOR_W:0]    trial_diff;
    logic                  trial_borrow;

    logic [DIVIDEND_W-1:0] q_next;
    logic [DIVISOR_W-1:0]  r_next;
    logic [DIVIDEND_W-1:0] quot_signed;
    logic [DIVISOR_W-1:0]  rem_signed;
    logic                  ovf_next;

    assign trial_a = {r_reg, q_reg[DIVIDEND_W-1]};
    assign trial_b = {1'b0, dvs_mag_reg};

    div_sub #(.W(DIVISOR_W + 1)) u_sub (
        .a      (trial_a),
        .b      (trial_b),
        .diff   (trial_diff),
        .borrow (trial_borrow)
    );

    always_comb begin
        q_next = {q_reg[DIVIDEND_W-2:0], ~trial_borrow};
        // Restore on borrow: keep the shifted remainder instead of the difference.
        r_next = trial_borrow ? trial_a[DIVISOR_W-1:0] : trial_diff[DIVISOR_W-1:0];
        quot_signed = neg_q_reg ? ((~q_next) + DIVIDEND_W'(1)) : q_next;
        rem_signed  = neg_r_reg ? ((~r_next) + DIVISOR_W'(1)) : r_next;
        // A negative quotient may reach magnitude 128; a positive one only 127.
        ovf_next = neg_q_reg ? (q_next > DIVIDEND_W'(128)) : (q_next > DIVIDEND_W'(127));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
            dvs_mag_reg <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            quot_reg    <= '0;
            rem_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            ovf_reg     <= 1'b0;
            dbz_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        q_reg       <= mag16(bus.dividend);
                        dvs_mag_reg <= mag8(bus.divisor);
                        r_reg       <= '0;
                        cnt_reg     <= '0;
                        neg_q_reg   <= bus.dividend[DIVIDEND_W-1] ^ bus.divisor[DIVISOR_W-1];
                        neg_r_reg   <= bus.dividend[DIVIDEND_W-1];
                        if (bus.divisor == '0) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                            dbz_reg   <= 1'b1;
                            ovf_reg   <= 1'b0;
                            quot_reg  <= '0;
                            rem_reg   <= bus.dividend[DIVISOR_W-1:0];
                        end else begin
                            state_reg <= ST_RUN;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    q_reg   <= q_next;
                    r_reg   <= r_next;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(ITER_N - 1)) begin
                        state_reg <= ST_DONE;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        quot_reg  <= quot_signed[DIVISOR_W-1:0];
                        rem_reg   <= rem_signed;
                        ovf_reg   <= ovf_next;
                        dbz_reg   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.quot = quot_reg;
    assign bus.rem  = rem_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.ovf  = ovf_reg;
    assign bus.dbz  = dbz_reg;

endmodule

// File: tb/tb_div_8bit.sv
module tb_div_8bit;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    div_8bit_if bus();

    div_8bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference: plain integer arithmetic (truncating division, remainder
    // following the dividend's sign).
    function automatic void model(input int dd, input int dv,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic o, output logic z,
                                  output int lat, output int bcnt);
        int qq;
        int rr;
        if (dv == 0) begin
            q = 8'h00; r = dd[7:0]; o = 1'b0; z = 1'b1; lat = 1; bcnt = 0;
        end else begin
            qq = dd / dv;
            rr = dd % dv;
            q = qq[7:0]; r = rr[7:0];
            o = (qq < -128) || (qq > 127);
            z = 1'b0; lat = 17; bcnt = 16;
        end
    endfunction

    // Waits (bounded) for done; lat counts edges from the accepting edge
    // (1 = done visible right after it). lat=-1 on timeout.
    task automatic wait_done(output int lat, output int bcnt);
        lat = -1;
        bcnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
            if (bus.busy === 1'b1) bcnt++;
            @(posedge clk);
        end
    endtask

    task automatic do_op(input int dd, input int dv, output int lat, output int bcnt);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = dd[15:0];
        bus.divisor  = dv[7:0];
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(lat, bcnt);
    endtask

    function automatic int rand_s16();
        logic [15:0] v;
        v = 16'($urandom);
        return int'($signed(v));
    endfunction

    function automatic int rand_s8();
        logic [7:0] v;
        v = 8'($urandom);
        return int'($signed(v));
    endfunction

    task automatic test_reset();
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        rst = 1'b1;
        #2;
        total++;
        if ({bus.quot, bus.rem, bus.busy, bus.done, bus.ovf, bus.dbz} !== 18'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {bus.quot, bus.rem, bus.busy, bus.done, bus.ovf, bus.dbz});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_directed();
        int dd_t [8] = '{100, -100, 100, 1000, -32768, 1234, -9, -128};
        int dv_t [8] = '{7, 7, -7, 3, -1, 0, 4, -128};
        logic [7:0] eq, er;
        logic eo, ez;
        int el, eb, lat, bcnt;
        for (int i = 0; i < 8; i++) begin
            model(dd_t[i], dv_t[i], eq, er, eo, ez, el, eb);
            do_op(dd_t[i], dv_t[i], lat, bcnt);
            $display("directed %0d/%0d -> quot=%h rem=%h ovf=%b dbz=%b lat=%0d",
                     dd_t[i], dv_t[i], bus.quot, bus.rem, bus.ovf, bus.dbz, lat);
            total += 6;
            if (lat !== el) begin bad++; $display("FAIL dir_lat[%0d]: got %0d want %0d", i, lat, el); end
            if (bus.quot !== eq) begin bad++; $display("FAIL dir_quot[%0d]: got %h want %h", i, bus.quot, eq); end
            if (bus.rem !== er) begin bad++; $display("FAIL dir_rem[%0d]: got %h want %h", i, bus.rem, er); end
            if (bus.ovf !== eo) begin bad++; $display("FAIL dir_ovf[%0d]: got %b want %b", i, bus.ovf, eo); end
            if (bus.dbz !== ez) begin bad++; $display("FAIL dir_dbz[%0d]: got %b want %b", i, bus.dbz, ez); end
            if (bcnt !== eb) begin bad++; $display("FAIL dir_busy_cycles[%0d]: got %0d want %0d", i, bcnt, eb); end
        end
        // done is a single pulse and results hold through IDLE.
        repeat (5) @(negedge clk);
        total += 2;
        if ({bus.done, bus.busy} !== 2'b00) begin
            bad++; $display("FAIL hold_flags: got %b want 00", {bus.done, bus.busy});
        end
        if ({bus.quot, bus.rem, bus.ovf, bus.dbz} !== {eq, er, eo, ez}) begin
            bad++; $display("FAIL hold_result: got %h want %h",
                            {bus.quot, bus.rem, bus.ovf, bus.dbz}, {eq, er, eo, ez});
        end
    endtask

    task automatic test_ignore_start();
        int lat, bcnt;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 16'd100; bus.divisor = 8'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 16'd50; bus.divisor = 8'd5;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(lat, bcnt);
        $display("ignore_start 100/7 -> quot=%h rem=%h total_lat=%0d", bus.quot, bus.rem, lat + 5);
        total += 3;
        if (lat + 5 !== 17) begin bad++; $display("FAIL ign_lat: got %0d want 17", lat + 5); end
        if (bus.quot !== 8'd14) begin bad++; $display("FAIL ign_quot: got %h want 0e", bus.quot); end
        if (bus.rem !== 8'd2) begin bad++; $display("FAIL ign_rem: got %h want 02", bus.rem); end
    endtask

    task automatic test_reset_in_run();
        int lat, bcnt, seen;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 16'd100; bus.divisor = 8'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bus.quot, bus.rem, bus.busy, bus.done, bus.ovf, bus.dbz} !== 18'h0) begin
            bad++;
            $display("FAIL run_reset_outputs: got %h want 0",
                     {bus.quot, bus.rem, bus.busy, bus.done, bus.ovf, bus.dbz});
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL run_reset_no_done: got %0d want 0", seen); end
        do_op(100, 7, lat, bcnt);
        $display("after_reset 100/7 -> quot=%h rem=%h lat=%0d", bus.quot, bus.rem, lat);
        total += 3;
        if (lat !== 17) begin bad++; $display("FAIL rr_lat: got %0d want 17", lat); end
        if (bus.quot !== 8'd14) begin bad++; $display("FAIL rr_quot: got %h want 0e", bus.quot); end
        if (bus.rem !== 8'd2) begin bad++; $display("FAIL rr_rem: got %h want 02", bus.rem); end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        do_op(50, 5, lat, bcnt);
        $display("b2b 50/5 -> quot=%h rem=%h lat=%0d", bus.quot, bus.rem, lat);
        total += 3;
        if (lat !== 17) begin bad++; $display("FAIL b2b1_lat: got %0d want 17", lat); end
        if (bus.quot !== 8'd10) begin bad++; $display("FAIL b2b1_quot: got %h want 0a", bus.quot); end
        if (bus.rem !== 8'd0) begin bad++; $display("FAIL b2b1_rem: got %h want 00", bus.rem); end
        // Raise start while done is showing; it must take effect in the following IDLE cycle.
        bus.start = 1'b1; bus.dividend = 16'hFFF7; bus.divisor = 8'd4;
        @(posedge clk);
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(lat, bcnt);
        $display("b2b -9/4 -> quot=%h rem=%h lat=%0d", bus.quot, bus.rem, lat);
        total += 3;
        if (lat !== 17) begin bad++; $display("FAIL b2b2_lat: got %0d want 17", lat); end
        if (bus.quot !== 8'hFE) begin bad++; $display("FAIL b2b2_quot: got %h want fe", bus.quot); end
        if (bus.rem !== 8'hFF) begin bad++; $display("FAIL b2b2_rem: got %h want ff", bus.rem); end
    endtask

    task automatic test_random();
        logic [7:0] eq, er;
        logic eo, ez;
        int el, eb, lat, bcnt, dd, dv;
        for (int i = 0; i < 60; i++) begin
            dd = rand_s16();
            dv = ($urandom_range(0, 7) == 0) ? 0 : rand_s8();
            if ($urandom_range(0, 3) == 0) dd = dd % 2000;
            model(dd, dv, eq, er, eo, ez, el, eb);
            do_op(dd, dv, lat, bcnt);
            $display("random %0d/%0d -> quot=%h rem=%h ovf=%b dbz=%b lat=%0d",
                     dd, dv, bus.quot, bus.rem, bus.ovf, bus.dbz, lat);
            total += 5;
            if (lat !== el) begin bad++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", i, lat, el); end
            if (bus.quot !== eq) begin bad++; $display("FAIL rnd_quot[%0d]: got %h want %h", i, bus.quot, eq); end
            if (bus.rem !== er) begin bad++; $display("FAIL rnd_rem[%0d]: got %h want %h", i, bus.rem, er); end
            if (bus.ovf !== eo) begin bad++; $display("FAIL rnd_ovf[%0d]: got %b want %b", i, bus.ovf, eo); end
            if (bus.dbz !== ez) begin bad++; $display("FAIL rnd_dbz[%0d]: got %b want %b", i, bus.dbz, ez); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_in_run();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
